mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 38 +++
 rtl/mem_ctrl_if.sv | 24 ++
 rtl/mem_decode.sv | 23 ++
 rtl/mem_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared memory-map constants, FSM encoding and helper types for the memory controller.
package mem_ctrl_pkg;

   localparam logic [15:0] RAM1_BASE      = 16'h8000;
   localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
   localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // One-hot access target produced by the address decoder
   typedef struct packed {
      logic uart_stat;
      logic uart_data;
      logic ram1;
      logic ram2;
   } target_t;

   typedef struct packed {
      logic en_n;
      logic oe_n;
      logic we_n;
      logic dq_oe;
   } sram_ctl_t;

   localparam sram_ctl_t CTL_IDLE = '{en_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};

   function automatic logic [15:0] uart_status_word(input logic data_ready,
                                                     input logic tbre,
                                                     input logic tsre);
      return {14'b0, data_ready, tbre & tsre};
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side fetch and data-access handshake bundle of the memory controller.
interface mem_ctrl_if;
   logic        if_req;
   logic [15:0] if_addr;
   logic [15:0] if_data;
   logic        if_done;
   logic        memread;
   logic        memwrite;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_done;
   logic        stall;

   modport master (
      output if_req, if_addr, memread, memwrite, mem_addr, mem_wdata,
      input  if_data, if_done, mem_rdata, mem_done, stall
   );

   modport slave (
      input  if_req, if_addr, memread, memwrite, mem_addr, mem_wdata,
      output if_data, if_done, mem_rdata, mem_done, stall
   );
endinterface

// File: rtl/mem_decode.sv
// Combinational address decoder: 16-bit address to one-hot device target.
module mem_decode
   import mem_ctrl_pkg::*;
(
   input  logic [15:0] addr_i,
   output target_t     target_o
);

   // RAM2 owns the low half; the two UART registers are carved out of RAM1's range
   always_comb begin
      target_o = '0;
      if (addr_i < RAM1_BASE) begin
         target_o.ram2 = 1'b1;
      end else if (addr_i == UART_DATA_ADDR) begin
         target_o.uart_data = 1'b1;
      end else if (addr_i == UART_STAT_ADDR) begin
         target_o.uart_stat = 1'b1;
      end else begin
         target_o.ram1 = 1'b1;
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// Four-state SRAM/UART access controller arbitrating instruction fetch and data accesses.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   mem_ctrl_if.slave   cpu,
   output logic [15:0] ram1_addr_o,
   input  logic [15:0] ram1_dq_i,
   output logic [15:0] ram1_dq_o,
   output logic        ram1_dq_oe_o,
   output logic        ram1_en_n_o,
   output logic        ram1_oe_n_o,
   output logic        ram1_we_n_o,
   output logic [15:0] ram2_addr_o,
   input  logic [15:0] ram2_dq_i,
   output logic [15:0] ram2_dq_o,
   output logic        ram2_dq_oe_o,
   output logic        ram2_en_n_o,
   output logic        ram2_oe_n_o,
   output logic        ram2_we_n_o,
   output logic        uart_rdn_o,
   output logic        uart_wrn_o,
   input  logic        uart_data_ready_i,
   input  logic        uart_tbre_i,
   input  logic        uart_tsre_i
);

   state_e      state_q, state_d;
   logic        is_data_q, is_data_d;
   logic        is_wr_q, is_wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   target_t     tgt_q, tgt_d;

   sram_ctl_t   ram1_ctl_q, ram1_ctl_d, ram2_ctl_q, ram2_ctl_d;
   logic [15:0] ram1_addr_q, ram1_addr_d, ram2_addr_q, ram2_addr_d;
   logic [15:0] ram1_dq_q, ram1_dq_d, ram2_dq_q, ram2_dq_d;
   logic        rdn_q, rdn_d, wrn_q, wrn_d;
   logic        if_done_q, if_done_d, mem_done_q, mem_done_d;
   logic [15:0] if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;

   logic        data_req_s, any_req_s, active_s, strobe_s;
   logic [15:0] sel_addr_s, rdata_s;
   target_t     sel_tgt_s;

   assign data_req_s = cpu.memread | cpu.memwrite;
   assign any_req_s  = data_req_s | cpu.if_req;
   assign sel_addr_s = data_req_s ? cpu.mem_addr : cpu.if_addr;

   mem_decode u_decode (
      .addr_i   (sel_addr_s),
      .target_o (sel_tgt_s)
   );

   // State sequencing; the winning request is latched on leaving IDLE
   always_comb begin
      state_d   = state_q;
      is_data_d = is_data_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tgt_d     = tgt_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               state_d   = ST_SETUP;
               is_data_d = data_req_s;
               is_wr_d   = cpu.memwrite;
               addr_d    = sel_addr_s;
               wdata_d   = cpu.mem_wdata;
               tgt_d     = sel_tgt_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP:  state_d = ST_STROBE;
         ST_STROBE: state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Read data source for the access ending this cycle
   always_comb begin
      if (tgt_q.ram2) begin
         rdata_s = ram2_dq_i;
      end else if (tgt_q.uart_stat) begin
         rdata_s = uart_status_word(uart_data_ready_i, uart_tbre_i, uart_tsre_i);
      end else begin
         rdata_s = ram1_dq_i;
      end
   end

   // Device controls are decoded from the upcoming state so the pins come straight from flops
   always_comb begin
      active_s    = (state_d == ST_SETUP) || (state_d == ST_STROBE);
      strobe_s    = (state_d == ST_STROBE);
      ram1_ctl_d  = CTL_IDLE;
      ram2_ctl_d  = CTL_IDLE;
      ram1_addr_d = 16'h0000;
      ram2_addr_d = 16'h0000;
      ram1_dq_d   = 16'h0000;
      ram2_dq_d   = 16'h0000;
      rdn_d       = 1'b1;
      wrn_d       = 1'b1;
      if (active_s) begin
         if (tgt_d.ram2) begin
            ram2_ctl_d.en_n  = 1'b0;
            ram2_ctl_d.dq_oe = is_wr_d;
            ram2_ctl_d.we_n  = ~(is_wr_d & strobe_s);
            ram2_ctl_d.oe_n  = ~(~is_wr_d & strobe_s);
            ram2_addr_d      = addr_d;
            ram2_dq_d        = is_wr_d ? wdata_d : 16'h0000;
         end else if (tgt_d.ram1) begin
            ram1_ctl_d.en_n  = 1'b0;
            ram1_ctl_d.dq_oe = is_wr_d;
            ram1_ctl_d.we_n  = ~(is_wr_d & strobe_s);
            ram1_ctl_d.oe_n  = ~(~is_wr_d & strobe_s);
            ram1_addr_d      = addr_d;
            ram1_dq_d        = is_wr_d ? wdata_d : 16'h0000;
         end else if (tgt_d.uart_data) begin
            ram1_ctl_d.dq_oe = is_wr_d;
            ram1_dq_d        = is_wr_d ? wdata_d : 16'h0000;
            wrn_d            = ~(is_wr_d & strobe_s);
            rdn_d            = ~(~is_wr_d & strobe_s);
         end else begin
            rdn_d = 1'b1;
         end
      end else begin
         rdn_d = 1'b1;
      end
      if_done_d   = (state_d == ST_DONE) & ~is_data_q;
      mem_done_d  = (state_d == ST_DONE) &  is_data_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      if (state_q == ST_STROBE) begin
         if (is_data_q) begin
            mem_rdata_d = rdata_s;
         end else begin
            if_data_d = rdata_s;
         end
      end else begin
         if_data_d = if_data_q;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         is_data_q   <= 1'b0;
         is_wr_q     <= 1'b0;
         addr_q      <= 16'h0000;
         wdata_q     <= 16'h0000;
         tgt_q       <= '0;
         ram1_ctl_q  <= CTL_IDLE;
         ram2_ctl_q  <= CTL_IDLE;
         ram1_addr_q <= 16'h0000;
         ram2_addr_q <= 16'h0000;
         ram1_dq_q   <= 16'h0000;
         ram2_dq_q   <= 16'h0000;
         rdn_q       <= 1'b1;
         wrn_q       <= 1'b1;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_data_q   <= 16'h0000;
         mem_rdata_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         is_data_q   <= is_data_d;
         is_wr_q     <= is_wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         tgt_q       <= tgt_d;
         ram1_ctl_q  <= ram1_ctl_d;
         ram2_ctl_q  <= ram2_ctl_d;
         ram1_addr_q <= ram1_addr_d;
         ram2_addr_q <= ram2_addr_d;
         ram1_dq_q   <= ram1_dq_d;
         ram2_dq_q   <= ram2_dq_d;
         rdn_q       <= rdn_d;
         wrn_q       <= wrn_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign cpu.stall     = ((state_q == ST_IDLE) & any_req_s) |
                          (state_q == ST_SETUP) | (state_q == ST_STROBE);
   assign cpu.if_done   = if_done_q;
   assign cpu.mem_done  = mem_done_q;
   assign cpu.if_data   = if_data_q;
   assign cpu.mem_rdata = mem_rdata_q;

   assign ram1_addr_o  = ram1_addr_q;
   assign ram1_dq_o    = ram1_dq_q;
   assign ram1_dq_oe_o = ram1_ctl_q.dq_oe;
   assign ram1_en_n_o  = ram1_ctl_q.en_n;
   assign ram1_oe_n_o  = ram1_ctl_q.oe_n;
   assign ram1_we_n_o  = ram1_ctl_q.we_n;
   assign ram2_addr_o  = ram2_addr_q;
   assign ram2_dq_o    = ram2_dq_q;
   assign ram2_dq_oe_o = ram2_ctl_q.dq_oe;
   assign ram2_en_n_o  = ram2_ctl_q.en_n;
   assign ram2_oe_n_o  = ram2_ctl_q.oe_n;
   assign ram2_we_n_o  = ram2_ctl_q.we_n;
   assign uart_rdn_o   = rdn_q;
   assign uart_wrn_o   = wrn_q;

endmodule
